vga_planar_fetch: RTL and testbench

VGA_PLANAR_FETCH -- requirements
Module: vga_planar_fetch

---
 rtl/vga_pkg.sv | 18 +
 rtl/vga_planar_fetch_if.sv | 20 ++
 rtl/vga_delay_line.sv | 28 ++
 rtl/vga_planar_fetch.sv | 163 ++++++++++++++++
 tb/tb_vga_planar_fetch.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared definitions for the planar VGA fetch engine.
//   fetch_state_e : fetch FSM state encoding
//   DEF_DW        : default memory data width (pixels per word per plane)
//   DEF_PLANES    : default number of bit planes
//   DEF_LAT       : default h_count-to-attr pipeline delay
package vga_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StFull
    } fetch_state_e;

    localparam int unsigned DEF_DW     = 16;
    localparam int unsigned DEF_PLANES = 4;
    localparam int unsigned DEF_LAT    = 10;

endpackage

// File: rtl/vga_planar_fetch_if.sv
// Memory read port of the planar fetch engine.
//   fml_adr_o : word address {word_offset, plane}
//   fml_stb_o : read request, held until acknowledged
//   fml_ack_i : read data valid, one cycle per request
//   fml_dat_i : read data
// master = fetch engine, slave = memory.
interface vga_planar_fetch_if
    import vga_pkg::*;
#(
    parameter int unsigned AW = 17,
    parameter int unsigned DW = DEF_DW
);
    logic [AW-1:0] fml_adr_o;
    logic          fml_stb_o;
    logic          fml_ack_i;
    logic [DW-1:0] fml_dat_i;

    modport master (output fml_adr_o, output fml_stb_o, input fml_ack_i, input fml_dat_i);
    modport slave  (input fml_adr_o, input fml_stb_o, output fml_ack_i, output fml_dat_i);
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth register delay line with clock enable.
//   clk, rst : clock, synchronous active-high reset (clears every stage)
//   enable   : shift only when high
//   din      : input word
//   dout     : din delayed DEPTH enabled cycles
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else if (enable) begin
            pipe_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/vga_planar_fetch.sv
// Planar VGA pixel fetch: per group of G dots, reads one word from each bit plane into
// staging, loads per-plane shift registers at a fixed pipeline point and emits one
// attribute per dot, aligned with the delayed horizontal sync / video flags.
//   clk, rst            : clock, synchronous active-high reset
//   enable              : clock enable; all state holds when low
//   fml                 : memory read port (master)
//   start_addr          : frame base word
//   line_offset         : words per scan line
//   pel_pan             : pixel pan, sampled at each shifter load
//   attr_plane_enable   : plane mask applied to attr
//   x_dotclockdiv2      : double-width pixels, v_count[0] ignored
//   h_count, v_count    : raster position
//   horiz_sync_i/_o     : sync flag in / delayed by LAT
//   video_on_h_i/_o     : video flag in / delayed by LAT
//   attr                : registered pixel attribute
//   underrun            : sticky flag, set when a fetch misses its load point
module vga_planar_fetch
    import vga_pkg::*;
#(
    parameter int unsigned DW     = DEF_DW,
    parameter int unsigned PLANES = DEF_PLANES,
    parameter int unsigned AW     = 17,
    parameter int unsigned LAT    = DEF_LAT,
    localparam int unsigned PW    = $clog2(PLANES),
    localparam int unsigned WW    = AW - PW,
    localparam int unsigned SW    = $clog2(DW),
    localparam int unsigned CW    = (PLANES > 1) ? PW : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    vga_planar_fetch_if.master fml,
    input  logic [WW-1:0]      start_addr,
    input  logic [9:0]         line_offset,
    input  logic [SW-1:0]      pel_pan,
    input  logic [PLANES-1:0]  attr_plane_enable,
    input  logic               x_dotclockdiv2,
    input  logic [9:0]         h_count,
    input  logic [9:0]         v_count,
    input  logic               horiz_sync_i,
    input  logic               video_on_h_i,
    output logic               horiz_sync_o,
    output logic               video_on_h_o,
    output logic [PLANES-1:0]  attr,
    output logic               underrun
);
    fetch_state_e  state_q, state_d;
    logic [CW-1:0] plane_q, plane_d;
    logic [WW-1:0] word_q, word_d, word_next;
    logic [DW-1:0] staging_q [PLANES];
    logic [DW-1:0] shift_q [PLANES];
    logic [DW-1:0] shift_d [PLANES];
    logic [DW-1:0] rotated [PLANES];
    logic [2*DW-1:0] rot_dbl [PLANES];
    logic [PLANES-1:0] attr_q, attr_d;
    logic underrun_q;
    logic capture, load, advance, group_start;
    logic [9:0] g_mask, col, line;
    logic [19:0] line_prod;

    // Group size G is a power of two, so "h_count mod G == 0" is a mask test.
    assign g_mask      = x_dotclockdiv2 ? 10'(2 * DW - 1) : 10'(DW - 1);
    assign group_start = enable & ((h_count & g_mask) == '0);
    assign col         = x_dotclockdiv2 ? (h_count >> (SW + 1)) : (h_count >> SW);
    assign line        = x_dotclockdiv2 ? {1'b0, v_count[9:1]} : v_count;
    assign line_prod   = line * line_offset;
    assign word_next   = start_addr + WW'(line_prod) + WW'(col);
    assign advance     = ~x_dotclockdiv2 | h_count[0];

    // Load point: group start delayed LAT-1 enabled cycles.
    vga_delay_line #(.WIDTH(1), .DEPTH(LAT - 1)) u_load_dly (
        .clk(clk), .rst(rst), .enable(enable), .din(group_start), .dout(load)
    );

    vga_delay_line #(.WIDTH(2), .DEPTH(LAT)) u_flag_dly (
        .clk(clk), .rst(rst), .enable(enable),
        .din({horiz_sync_i, video_on_h_i}), .dout({horiz_sync_o, video_on_h_o})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            plane_q <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        word_d  = word_q;
        capture = 1'b0;
        if (enable) begin
            unique case (state_q)
                StReq: begin
                    if (fml.fml_ack_i) begin
                        capture = 1'b1;
                        if (plane_q == CW'(PLANES - 1)) state_d = StFull;
                        else plane_d = plane_q + 1'b1;
                    end
                end
                StFull:  if (load) state_d = StIdle;
                default: ;
            endcase
            // Fetch still running at the load point: abandon it.
            if (load && state_q != StFull) state_d = StIdle;
            // Checked after the load so a coinciding group start opens the next fetch.
            if (group_start && state_d == StIdle) begin
                state_d = StReq;
                plane_d = '0;
                word_d  = word_next;
            end
        end
    end

    assign fml.fml_stb_o = (state_q == StReq);

    if (PW == 0) begin : g_one_plane
        assign fml.fml_adr_o = word_q;
    end else begin : g_planes
        assign fml.fml_adr_o = {word_q, plane_q[PW-1:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PLANES; p++) staging_q[p] <= '0;
        end else if (capture) begin
            staging_q[plane_q] <= fml.fml_dat_i;
        end
    end

    always_comb begin
        for (int p = 0; p < PLANES; p++) begin
            // Rotate left by pel_pan: upper half of the doubled word shifted left.
            rot_dbl[p] = {staging_q[p], staging_q[p]} << pel_pan;
            rotated[p] = rot_dbl[p][2*DW-1:DW];
            shift_d[p] = shift_q[p];
            if (load) shift_d[p] = (state_q == StFull) ? rotated[p] : '0;
            else if (advance) shift_d[p] = shift_q[p] << 1;
            // Taken from the next shifter value so attr lines up with the delayed flags.
            attr_d[p] = shift_d[p][DW-1] & attr_plane_enable[p];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < PLANES; p++) shift_q[p] <= '0;
            attr_q     <= '0;
            underrun_q <= 1'b0;
        end else if (enable) begin
            shift_q <= shift_d;
            attr_q  <= attr_d;
            if (load && state_q != StFull) underrun_q <= 1'b1;
        end
    end

    assign attr     = attr_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_vga_planar_fetch.sv
// Directed bench for vga_planar_fetch. Each scenario resets the block, then runs a raster
// with h_count = cycle index k (group starts at k = 0, G, 2G, ...). A small memory
// responder acks each request after wait_n + 1 cycles with the word for that plane.
module tb_vga_planar_fetch;
    logic        clk;
    logic        rst;
    logic        enable;
    logic [14:0] start_addr;
    logic [9:0]  line_offset;
    logic [3:0]  pel_pan;
    logic [3:0]  attr_plane_enable;
    logic        x_dotclockdiv2;
    logic [9:0]  h_count;
    logic [9:0]  v_count;
    logic        horiz_sync_i;
    logic        video_on_h_i;
    logic        horiz_sync_o;
    logic        video_on_h_o;
    logic [3:0]  attr;
    logic        underrun;

    logic [15:0] plane_data [4];
    int k;
    int cnt;
    int wait_n;
    int n_vec;
    int n_err;

    vga_planar_fetch_if #(.AW(17), .DW(16)) fml ();

    vga_planar_fetch #(.DW(16), .PLANES(4), .AW(17), .LAT(10)) dut (
        .clk(clk), .rst(rst), .enable(enable), .fml(fml),
        .start_addr(start_addr), .line_offset(line_offset), .pel_pan(pel_pan),
        .attr_plane_enable(attr_plane_enable), .x_dotclockdiv2(x_dotclockdiv2),
        .h_count(h_count), .v_count(v_count),
        .horiz_sync_i(horiz_sync_i), .video_on_h_i(video_on_h_i),
        .horiz_sync_o(horiz_sync_o), .video_on_h_o(video_on_h_o),
        .attr(attr), .underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    // One clock: memory decides next-cycle ack from this cycle's request, then inputs advance.
    task automatic tick();
        logic        nack;
        logic [15:0] ndat;
        nack = 1'b0;
        ndat = 16'hDEAD;
        if (fml.fml_stb_o && !fml.fml_ack_i) begin
            if (cnt >= wait_n) begin
                nack = 1'b1;
                cnt  = 0;
                ndat = plane_data[fml.fml_adr_o[1:0]];
            end else begin
                cnt++;
            end
        end else if (!fml.fml_stb_o) begin
            cnt = 0;
        end
        @(posedge clk);
        #1;
        fml.fml_ack_i = nack;
        fml.fml_dat_i = ndat;
        k++;
        h_count      = 10'(k);
        horiz_sync_i = (k == 5);
        video_on_h_i = (k >= 2);
        #1;
    endtask

    task automatic run_to(input int n);
        while (k < n) tick();
    endtask

    task automatic setup(input logic xd, input logic [9:0] v, input logic [9:0] lo,
                         input logic [3:0] pan, input logic [3:0] mask, input int wt,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3);
        x_dotclockdiv2    = xd;
        v_count           = v;
        line_offset       = lo;
        start_addr        = '0;
        pel_pan           = pan;
        attr_plane_enable = mask;
        wait_n            = wt;
        plane_data[0] = d0;
        plane_data[1] = d1;
        plane_data[2] = d2;
        plane_data[3] = d3;
        rst = 1'b1;
        k = 0;
        cnt = 0;
        h_count = '0;
        horiz_sync_i = 1'b0;
        video_on_h_i = 1'b0;
        fml.fml_ack_i = 1'b0;
        fml.fml_dat_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        enable = 1'b1;
        rst = 1'b1;
        fml.fml_ack_i = 1'b0;
        fml.fml_dat_i = '0;

        // 1: zero-wait, v=3, pitch 40, plane0 = 0x8000
        setup(1'b0, 10'd3, 10'd40, 4'd0, 4'hF, 0, 16'h8000, 16'h0, 16'h0, 16'h0);
        chk("rst_stb", fml.fml_stb_o, 0);
        chk("rst_adr", fml.fml_adr_o, 0);
        chk("rst_attr", attr, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_hsync_o", horiz_sync_o, 0);
        chk("rst_video_o", video_on_h_o, 0);
        run_to(1);
        chk("s1_stb_req0", fml.fml_stb_o, 1);
        chk("s1_adr_g0p0", fml.fml_adr_o, 17'h1E0);
        run_to(2);
        chk("s1_adr_hold", fml.fml_adr_o, 17'h1E0);
        run_to(3);
        chk("s1_adr_g0p1", fml.fml_adr_o, 17'h1E1);
        run_to(9);
        chk("s1_stb_full", fml.fml_stb_o, 0);
        run_to(10);
        chk("s1_attr_first", attr, 4'h1);
        for (int i = 11; i <= 25; i++) begin
            run_to(i);
            chk("s1_attr_dark", attr, 0);
            case (i)
                11: chk("s1_video_o_low", video_on_h_o, 0);
                12: chk("s1_video_o_high", video_on_h_o, 1);
                14: chk("s1_hsync_o_before", horiz_sync_o, 0);
                15: chk("s1_hsync_o_pulse", horiz_sync_o, 1);
                16: chk("s1_hsync_o_after", horiz_sync_o, 0);
                17: chk("s1_adr_g1p0", fml.fml_adr_o, 17'h1E4);
                19: chk("s1_adr_g1p1", fml.fml_adr_o, 17'h1E5);
                21: chk("s1_adr_g1p2", fml.fml_adr_o, 17'h1E6);
                23: chk("s1_adr_g1p3", fml.fml_adr_o, 17'h1E7);
                default: ;
            endcase
        end
        run_to(26);
        chk("s1_attr_group1", attr, 4'h1);
        run_to(33);
        chk("s1_adr_g2p0", fml.fml_adr_o, 17'h1E8);
        chk("s1_underrun", underrun, 0);

        // 2: double-width pixels, v=5 -> line 2, pitch 20, G = 32
        setup(1'b1, 10'd5, 10'd20, 4'd0, 4'hF, 0, 16'hA000, 16'h0, 16'h0, 16'h0);
        run_to(1);
        chk("s2_adr_g0", fml.fml_adr_o, 17'h0A0);
        run_to(10);
        chk("s2_attr_10", attr, 4'h1);
        run_to(11);
        chk("s2_attr_11", attr, 4'h1);
        run_to(12);
        chk("s2_attr_12", attr, 4'h0);
        run_to(13);
        chk("s2_attr_13", attr, 4'h0);
        run_to(14);
        chk("s2_attr_14", attr, 4'h1);
        run_to(15);
        chk("s2_attr_15", attr, 4'h1);
        run_to(16);
        chk("s2_attr_16", attr, 4'h0);
        run_to(17);
        chk("s2_no_start_16", fml.fml_stb_o, 0);
        run_to(33);
        chk("s2_adr_g1", fml.fml_adr_o, 17'h0A4);

        // 3: pel_pan = 3, plane0 = 0x1000, plane1 = 0x0001
        setup(1'b0, 10'd0, 10'd40, 4'd3, 4'hF, 0, 16'h1000, 16'h0001, 16'h0, 16'h0);
        run_to(10);
        chk("s3_pan_first", attr, 4'h1);
        run_to(11);
        chk("s3_pan_second", attr, 4'h0);
        run_to(21);
        chk("s3_pan_21", attr, 4'h0);
        run_to(22);
        chk("s3_pan_p1", attr, 4'h2);

        // 4: 8-cycle ack latency on the first group, zero-wait afterwards
        setup(1'b0, 10'd1, 10'd40, 4'd0, 4'hF, 7, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_to(1);
        chk("s4_stb", fml.fml_stb_o, 1);
        run_to(8);
        chk("s4_still_p0", fml.fml_adr_o, 17'h0A0);
        run_to(9);
        chk("s4_underrun_pre", underrun, 0);
        run_to(10);
        wait_n = 0;
        chk("s4_underrun_set", underrun, 1);
        chk("s4_abort_stb", fml.fml_stb_o, 0);
        chk("s4_attr_10", attr, 0);
        run_to(17);
        chk("s4_attr_17", attr, 0);
        chk("s4_adr_g1", fml.fml_adr_o, 17'h0A4);
        run_to(25);
        chk("s4_attr_25", attr, 0);
        run_to(26);
        chk("s4_attr_recover", attr, 4'hF);
        chk("s4_underrun_sticky", underrun, 1);

        // 5: reset while in REQ(2), ack lands the cycle after
        setup(1'b0, 10'd0, 10'd40, 4'd0, 4'hF, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_to(5);
        chk("s5_req2_adr", fml.fml_adr_o, 17'h002);
        rst = 1'b1;
        run_to(6);
        rst = 1'b0;
        chk("s5_stb_after_rst", fml.fml_stb_o, 0);
        chk("s5_adr_after_rst", fml.fml_adr_o, 0);
        run_to(7);
        for (int p = 0; p < 4; p++) chk("s5_staging", dut.staging_q[p], 0);
        chk("s5_stb_idle", fml.fml_stb_o, 0);
        run_to(10);
        chk("s5_underrun", underrun, 0);
        chk("s5_attr", attr, 0);

        // 6: plane mask 0101, all planes 0xFFFF
        setup(1'b0, 10'd0, 10'd40, 4'd0, 4'b0101, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        run_to(9);
        chk("s6_attr_9", attr, 0);
        run_to(10);
        chk("s6_attr_10", attr, 4'b0101);
        run_to(17);
        chk("s6_attr_17", attr, 4'b0101);
        run_to(25);
        chk("s6_attr_25", attr, 4'b0101);
        run_to(26);
        chk("s6_attr_26", attr, 4'b0101);
        run_to(40);
        chk("s6_attr_40", attr, 4'b0101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
